mux_acc_stage: RTL and testbench
================================

Name: mux_acc_stage

Overview:
- Accumulator stage directly downstream of the 2x1 operand multiplexer; its din port is driven by the mux output y.
- On a start command it sums a fixed number (Count) of Size-bit operands presented with a valid strobe.
- It then flags completion with a one-cycle done pulse and holds the result for the next datapath stage.

Parameters:
- Size, 8, operand and accumulator width in bits; must match the upstream mux Size.
- Count, 4, number of operands summed per run; legal range 1..255.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begins a run; sampled only in IDLE.
- din  input  Size  operand, driven by the mux output y.
- din_valid  input  1  din is accepted on an edge where din_valid=1 and state=ACC.
- acc  output  Size  running and final sum, registered.
- carry  output  1  sticky overflow: 1 if any addition in the run overflowed Size bits.
- cnt  output  8  number of operands accepted in the current or last run.
- busy  output  1  1 while in ACC.
- done  output  1  1 for exactly one cycle, in DONE.

Behaviour:
- Reset (rst=1, asynchronous, any state): state=IDLE, acc=0, carry=0, cnt=0, busy=0, done=0. This takes effect immediately, including mid-run. A partial sum is discarded and no done is produced.
- States: IDLE, ACC, DONE. busy = (state==ACC); done = (state==DONE). Both are decoded from registered state and are glitch-free.
- IDLE:
  - start=1 at edge k: acc<=0, carry<=0, cnt<=0, state<=ACC. busy=1 from edge k.
  - din_valid in IDLE is ignored.
  - acc, carry and cnt hold their last values.
- ACC, on each edge with din_valid=1:
  - {c, acc} <= acc + din, as a (Size+1)-bit sum; acc wraps modulo 2^Size.
  - carry <= carry | c.
  - cnt <= cnt+1.
  - When the accepted operand is the Count-th (cnt==Count-1 before the edge), state<=DONE.
- ACC, on edges with din_valid=0: nothing changes. Gaps between operands are unlimited; there is no timeout.
- start is ignored in ACC and DONE. It does not restart or clear the run.
- DONE: lasts exactly one cycle. done=1, busy=0, and acc/carry/cnt hold the final values. Next edge: state<=IDLE.
- start=1 in DONE is ignored. A new run needs start in IDLE, i.e. no earlier than 2 cycles after the last operand.
- Latency:
  - The first operand can be accepted at edge k+1 after start at edge k.
  - Last operand accepted at edge m gives done=1 in the cycle between edges m and m+1.
  - Minimum run is Count+1 edges from start to DONE entry.
- Results remain stable on acc/carry/cnt from DONE until the next accepted start.

Test Plan:
- Reset then start; din=10,20,30,40 with din_valid=1 on consecutive edges -> acc=100, carry=0, cnt=4. done high exactly one cycle, right after the 4th accepting edge. busy=0 afterwards and the values hold.
- Overflow: din=200,100,1,1 -> acc=46 (302 mod 256), carry=1 and stays 1 through DONE. A following run of 1,1,1,1 -> acc=4, carry=0 (cleared at start).
- Gaps: din_valid toggled 1,0,0,1,0,1,1 with din=5 when valid -> acc=20, cnt=4. Values offered while din_valid=0 (din=99) are not summed.
- Start while busy: pulse start after 2 operands of 7,7 then send 7,7 -> run is not restarted; acc=28, single done pulse. start held high through DONE -> no new run until IDLE.
- Asynchronous reset mid-run: after 3 operands assert rst between clock edges -> acc, cnt, carry, busy and done go to 0 immediately without waiting for an edge. No done pulse. The next start runs normally.
- Count=1, Size=4: start, din=15 -> acc=15, carry=0, done one cycle after the accepting edge. Then start, din=15 -> acc=15 again. IDLE din_valid pulses are ignored.

Source files
------------

// File: rtl/mux_acc_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mux_acc_stage
//  Description : Accumulator stage fed by the 2x1 operand mux output. On a
//                start command it sums COUNT operands of SIZE bits presented
//                with a valid strobe, tracks a sticky overflow flag, pulses
//                done for one cycle and holds the result for the next stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_acc_stage #(
    parameter int SIZE  = 8,   // operand / accumulator width, matches upstream mux
    parameter int COUNT = 4    // operands per run, 1..255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [SIZE-1:0] din,
    input  logic            din_valid,
    output logic [SIZE-1:0] acc,
    output logic            carry,
    output logic [7:0]      cnt,
    output logic            busy,
    output logic            done
);

    // State encoding chosen so busy and done are single register bits:
    // bit 0 = ACC, bit 1 = DONE. The decoded outputs are therefore glitch-free.
    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_ACC  = 2'b01;
    localparam logic [1:0] S_DONE = 2'b10;

    // Operand count value seen before the edge that accepts the final operand.
    localparam logic [7:0] C_LAST_IDX = 8'(COUNT - 1);

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [SIZE-1:0] r_acc;
    logic            r_carry;
    logic [7:0]      r_cnt;

    logic            w_start_run;
    logic            w_accept;
    logic            w_last;
    logic [SIZE:0]   w_sum;

    // A run begins only from IDLE; start is ignored everywhere else.
    assign w_start_run = (r_state == S_IDLE) && start;

    // Operands are taken only while accumulating and strobed valid.
    assign w_accept    = (r_state == S_ACC) && din_valid;

    // The accepted operand is the final one of the run.
    assign w_last      = w_accept && (r_cnt == C_LAST_IDX);

    // One extra bit captures the carry out of this particular addition.
    assign w_sum       = {1'b0, r_acc} + {1'b0, din};

    // Next-state selection: IDLE -> ACC on start, ACC -> DONE on last operand,
    // DONE always returns to IDLE after its single cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_ACC;
                end
            end
            S_ACC: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register; reset aborts any run in progress without a done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath: clear on run start, accumulate on accepted operands, otherwise
    // hold so the last result stays visible until the next start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= 8'd0;
        end else if (w_start_run) begin
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= 8'd0;
        end else if (w_accept) begin
            r_acc   <= w_sum[SIZE-1:0];
            r_carry <= r_carry | w_sum[SIZE];
            r_cnt   <= r_cnt + 8'd1;
        end
    end

    assign acc   = r_acc;
    assign carry = r_carry;
    assign cnt   = r_cnt;
    assign busy  = r_state[0];
    assign done  = r_state[1];

endmodule
`default_nettype wire

// File: tb/tb_mux_acc_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux_acc_stage
//  Description : Self-checking bench for mux_acc_stage. Two instances
//                (SIZE=8/COUNT=4 and SIZE=4/COUNT=1) run directed scenarios
//                and random traffic against a run-level reference model that
//                keeps the operand total and count of the current run.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_acc_stage;

    localparam int C_SIZE_A  = 8;
    localparam int C_COUNT_A = 4;
    localparam int C_SIZE_B  = 4;
    localparam int C_COUNT_B = 1;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic                a_start = 1'b0;
    logic                a_valid = 1'b0;
    logic [C_SIZE_A-1:0] a_din   = '0;
    logic [C_SIZE_A-1:0] a_acc;
    logic                a_carry;
    logic [7:0]          a_cnt;
    logic                a_busy;
    logic                a_done;

    logic                b_start = 1'b0;
    logic                b_valid = 1'b0;
    logic [C_SIZE_B-1:0] b_din   = '0;
    logic [C_SIZE_B-1:0] b_acc;
    logic                b_carry;
    logic [7:0]          b_cnt;
    logic                b_busy;
    logic                b_done;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model of one run: whether a run is collecting operands,
    // whether the done cycle is showing, and the true (unwrapped) total.
    typedef struct {
        bit running;
        bit showing_done;
        int total;
        int n;
    } mdl_t;

    mdl_t ma = '{0, 0, 0, 0};
    mdl_t mb = '{0, 0, 0, 0};

    always #5 clk = ~clk;

    mux_acc_stage #(.SIZE(C_SIZE_A), .COUNT(C_COUNT_A)) u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .start     (a_start),
        .din       (a_din),
        .din_valid (a_valid),
        .acc       (a_acc),
        .carry     (a_carry),
        .cnt       (a_cnt),
        .busy      (a_busy),
        .done      (a_done)
    );

    mux_acc_stage #(.SIZE(C_SIZE_B), .COUNT(C_COUNT_B)) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .start     (b_start),
        .din       (b_din),
        .din_valid (b_valid),
        .acc       (b_acc),
        .carry     (b_carry),
        .cnt       (b_cnt),
        .busy      (b_busy),
        .done      (b_done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got=%0d expected=%0d", tag, $time, got, exp);
        end
    endtask

    // Advance the run model across one clock edge given the inputs seen there.
    task automatic mstep(inout mdl_t m, input bit r, input bit s, input bit v,
                         input int d, input int count);
        if (r) begin
            m = '{0, 0, 0, 0};
        end else if (m.showing_done) begin
            m.showing_done = 0;
        end else if (m.running) begin
            if (v) begin
                m.total += d;
                m.n++;
                if (m.n == count) begin
                    m.running      = 0;
                    m.showing_done = 1;
                end
            end
        end else if (s) begin
            m = '{1, 0, 0, 0};
        end
    endtask

    // The result wraps modulo 2^size; since the running total only grows,
    // some addition overflowed exactly when the true total reaches 2^size.
    task automatic cmp_a();
        chk("a_acc",   32'(a_acc),   32'(ma.total % (1 << C_SIZE_A)));
        chk("a_carry", 32'(a_carry), 32'(ma.total >= (1 << C_SIZE_A)));
        chk("a_cnt",   32'(a_cnt),   32'(ma.n));
        chk("a_busy",  32'(a_busy),  32'(ma.running));
        chk("a_done",  32'(a_done),  32'(ma.showing_done));
    endtask

    task automatic cmp_b();
        chk("b_acc",   32'(b_acc),   32'(mb.total % (1 << C_SIZE_B)));
        chk("b_carry", 32'(b_carry), 32'(mb.total >= (1 << C_SIZE_B)));
        chk("b_cnt",   32'(b_cnt),   32'(mb.n));
        chk("b_busy",  32'(b_busy),  32'(mb.running));
        chk("b_done",  32'(b_done),  32'(mb.showing_done));
    endtask

    task automatic tick();
        @(posedge clk);
        mstep(ma, rst, a_start, a_valid, int'(a_din), C_COUNT_A);
        mstep(mb, rst, b_start, b_valid, int'(b_din), C_COUNT_B);
        #1;
        cmp_a();
        cmp_b();
    endtask

    task automatic a_cyc(input bit s, input bit v, input int d);
        a_start = s;
        a_valid = v;
        a_din   = C_SIZE_A'(d);
        tick();
    endtask

    task automatic b_cyc(input bit s, input bit v, input int d);
        b_start = s;
        b_valid = v;
        b_din   = C_SIZE_B'(d);
        tick();
    endtask

    initial begin
        #1 rst = 1'b1;
        #1;
        chk("rst_acc",  32'(a_acc),  32'd0);
        chk("rst_busy", 32'(a_busy), 32'd0);
        chk("rst_done", 32'(a_done), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // basic run 10+20+30+40
        a_cyc(1, 0, 0);
        a_cyc(0, 1, 10);
        a_cyc(0, 1, 20);
        a_cyc(0, 1, 30);
        a_cyc(0, 1, 40);
        chk("basic_acc",  32'(a_acc),  32'd100);
        chk("basic_done", 32'(a_done), 32'd1);
        a_cyc(0, 0, 0);
        chk("basic_hold", 32'(a_acc),  32'd100);
        a_cyc(0, 1, 55);

        // overflow then carry cleared by the next start
        a_cyc(1, 0, 0);
        a_cyc(0, 1, 200);
        a_cyc(0, 1, 100);
        a_cyc(0, 1, 1);
        a_cyc(0, 1, 1);
        chk("ovf_acc",   32'(a_acc),   32'd46);
        chk("ovf_carry", 32'(a_carry), 32'd1);
        a_cyc(0, 0, 0);
        a_cyc(1, 0, 0);
        for (int i = 0; i < 4; i++) a_cyc(0, 1, 1);
        chk("ovf2_acc",   32'(a_acc),   32'd4);
        chk("ovf2_carry", 32'(a_carry), 32'd0);
        a_cyc(0, 0, 0);

        // gaps: values offered without valid are not summed
        a_cyc(1, 0, 0);
        a_cyc(0, 1, 5);
        a_cyc(0, 0, 99);
        a_cyc(0, 0, 99);
        a_cyc(0, 1, 5);
        a_cyc(0, 0, 99);
        a_cyc(0, 1, 5);
        a_cyc(0, 1, 5);
        chk("gap_acc", 32'(a_acc), 32'd20);
        chk("gap_cnt", 32'(a_cnt), 32'd4);
        a_cyc(0, 0, 0);

        // start while busy does not restart
        a_cyc(1, 0, 0);
        a_cyc(0, 1, 7);
        a_cyc(0, 1, 7);
        a_cyc(1, 0, 0);
        a_cyc(0, 1, 7);
        a_cyc(0, 1, 7);
        chk("busy_start_acc", 32'(a_acc), 32'd28);
        a_cyc(0, 0, 0);

        // start held high through DONE: new run only from IDLE
        a_cyc(1, 0, 0);
        a_cyc(1, 1, 3);
        a_cyc(1, 1, 3);
        a_cyc(1, 1, 3);
        a_cyc(1, 1, 3);
        chk("held_done", 32'(a_done), 32'd1);
        a_cyc(1, 0, 0);
        chk("held_idle_acc", 32'(a_acc), 32'd12);
        a_cyc(0, 1, 2);
        a_cyc(0, 1, 2);
        a_cyc(0, 1, 2);
        a_cyc(0, 1, 2);
        a_cyc(0, 0, 0);

        // asynchronous reset mid-run
        a_cyc(1, 0, 0);
        a_cyc(0, 1, 200);
        a_cyc(0, 1, 200);
        a_cyc(0, 1, 1);
        a_start = 1'b0;
        a_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("arst_acc",   32'(a_acc),   32'd0);
        chk("arst_carry", 32'(a_carry), 32'd0);
        chk("arst_cnt",   32'(a_cnt),   32'd0);
        chk("arst_busy",  32'(a_busy),  32'd0);
        chk("arst_done",  32'(a_done),  32'd0);
        tick();
        rst = 1'b0;
        a_cyc(1, 0, 0);
        a_cyc(0, 1, 1);
        a_cyc(0, 1, 2);
        a_cyc(0, 1, 3);
        a_cyc(0, 1, 4);
        chk("post_rst_acc", 32'(a_acc), 32'd10);
        a_cyc(0, 0, 0);

        // single-operand, 4-bit instance
        b_cyc(0, 1, 3);
        b_cyc(1, 0, 0);
        b_cyc(0, 1, 15);
        chk("b1_acc",  32'(b_acc),  32'd15);
        chk("b1_done", 32'(b_done), 32'd1);
        b_cyc(0, 1, 7);
        b_cyc(1, 0, 0);
        b_cyc(0, 1, 15);
        chk("b2_acc", 32'(b_acc), 32'd15);
        b_cyc(0, 1, 5);
        b_cyc(0, 0, 0);

        // random traffic on both instances
        for (int i = 0; i < 600; i++) begin
            a_start = ($urandom_range(0, 3) == 0);
            a_valid = $urandom_range(0, 1) != 0;
            a_din   = C_SIZE_A'($urandom);
            b_start = ($urandom_range(0, 2) == 0);
            b_valid = $urandom_range(0, 1) != 0;
            b_din   = C_SIZE_B'($urandom);
            rst     = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
